// File: rtl/wb_master_interface.sv
// wb_master_interface: single-outstanding Wishbone classic master behind a valid/ready command port.
// Latency: rsp_valid one cycle after ACK_I is sampled; 3 cycles minimum from command accept to response.
// Backpressure: cmd_ready low outside IDLE or while ACK_I is high; `WB_TIMEOUT_EN adds an ACK timeout abort.
module wb_master_interface #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  typedef enum logic [1:0] {IDLE, BUS, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        stb_q, stb_d;
  logic        cyc_q, cyc_d;
  logic        rvld_q, rvld_d;

`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  // Parameter only matters for the timeout build.
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
`endif

  // A lingering ACK from the previous slave access blocks new commands.
  assign cmd_ready = (state_q == IDLE) && !ACK_I;

  // Next-state and bus/response register updates.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    stb_d   = stb_q;
    cyc_d   = cyc_q;
    rvld_d  = 1'b0;
`ifdef WB_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          adr_d   = cmd_addr;
          we_d    = cmd_we;
          if (cmd_we) dat_d = cmd_wdata;
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // ACK takes priority over a timeout landing in the same cycle.
        if (ACK_I) begin
          rdata_d = we_q ? 32'h0 : DAT_I;
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          rvld_d  = 1'b1;
`ifdef WB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = RELEASE;
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = 32'h0;
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          rvld_d  = 1'b1;
          err_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (!ACK_I) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= IDLE;
      adr_q   <= 32'h0;
      dat_q   <= 32'h0;
      rdata_q <= 32'h0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      rvld_q  <= 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      cyc_q   <= cyc_d;
      rvld_q  <= rvld_d;
`ifdef WB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign ADR_O     = adr_q;
  assign DAT_O     = dat_q;
  assign WE_O      = we_q;
  assign STB_O     = stb_q;
  assign CYC_O     = cyc_q;
  assign rsp_valid = rvld_q;
  assign rsp_rdata = rdata_q;
`ifdef WB_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_interface.sv
// tb_wb_master_interface: bench for the Wishbone master bridge.
// A behavioural slave answers STB_O after a programmable delay and holds ACK_I past STB_O drop.
// Expected responses are queued at command issue and compared when rsp_valid pulses.
`timescale 1ns/1ps
module tb_wb_master_interface;

  logic        CLK_I;
  logic        RST_I;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic        WE_O;
  logic        STB_O;
  logic        CYC_O;
  logic [31:0] DAT_I;
  logic        ACK_I;

  int errors = 0;
  int checks = 0;
  int rsp_cnt = 0;
  int bad_rise = 0;
  logic [32:0] exp_q[$];   // {err, rdata}

  int          ack_delay = 1;
  int          ack_hold = 0;
  logic [31:0] slave_data = 32'h0;
  bit          force_ack = 0;

  wb_master_interface #(.TIMEOUT_CYCLES(16)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I)
  );

  initial begin
    CLK_I = 0;
    forever #5 CLK_I = ~CLK_I;
  end

  // Behavioural slave: ACK after ack_delay strobe cycles, hold ack_hold cycles after STB_O drops.
  initial begin
    int stb_cnt;
    int hold_left;
    stb_cnt = 0;
    hold_left = 0;
    ACK_I = 0;
    DAT_I = 32'h0;
    forever begin
      @(posedge CLK_I); #1;
      if (force_ack) begin
        ACK_I = 1;
        hold_left = 0;
      end else if (ACK_I) begin
        if (!STB_O && !CYC_O) begin
          if (hold_left > 0) hold_left--;
          else begin
            ACK_I = 0;
            DAT_I = 32'hBAD0_0000;
          end
        end
      end else if (STB_O && CYC_O) begin
        if (stb_cnt >= ack_delay) begin
          ACK_I = 1;
          DAT_I = slave_data;
          hold_left = ack_hold;
          stb_cnt = 0;
        end else stb_cnt++;
      end else stb_cnt = 0;
    end
  end

  // Response scoreboard and stale-ACK strobe watcher.
  initial begin
    logic [32:0] e;
    logic stb_prev;
    stb_prev = 0;
    forever begin
      @(negedge CLK_I);
      if (STB_O === 1'b1 && !stb_prev && ACK_I === 1'b1) bad_rise++;
      stb_prev = (STB_O === 1'b1);
      if (rsp_valid === 1'b1) begin
        rsp_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp rdata=%h err=%b with nothing outstanding", rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err, rsp_rdata} !== e) begin
            errors++;
            $display("FAIL rsp_payload got err=%b rdata=%h want err=%b rdata=%h",
                     rsp_err, rsp_rdata, e[32], e[31:0]);
          end
        end
      end
    end
  end

  // Present a command and hold it until accepted; returns at posedge+1 after the accept edge.
  task automatic send_cmd(input logic we, input logic [31:0] a, input logic [31:0] d, output logic ok);
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK_I);
      if (cmd_ready === 1'b1) ok = 1;
      @(posedge CLK_I); #1;
    end
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int target, output logic ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK_I); #1;
      if (rsp_cnt >= target) ok = 1;
    end
    @(posedge CLK_I); #1;
  endtask

  task automatic test_reset;
    RST_I = 0;
    #1;
    checks++; if ({STB_O, CYC_O, WE_O} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got=%b want=000", {STB_O, CYC_O, WE_O}); end
    checks++; if (ADR_O !== 32'h0 || DAT_O !== 32'h0) begin errors++; $display("FAIL reset_bus adr=%h dat=%h want 0", ADR_O, DAT_O); end
    checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin errors++; $display("FAIL reset_rsp vld=%b err=%b rdata=%h want 0", rsp_valid, rsp_err, rsp_rdata); end
    repeat (2) @(posedge CLK_I);
    @(negedge CLK_I); RST_I = 1;
    @(negedge CLK_I);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    @(posedge CLK_I); #1;
  endtask

  task automatic test_write;
    logic ok;
    int stb_cyc;
    int base;
    ack_delay = 3; ack_hold = 0; base = rsp_cnt; stb_cyc = 0;
    exp_q.push_back({1'b0, 32'h0});
    send_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL write_accept got=%b want=1", ok); end
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK_I);
      if (STB_O !== 1'b1) break;
      stb_cyc++;
      checks++;
      if (ADR_O !== 32'h10 || DAT_O !== 32'hDEAD_BEEF || WE_O !== 1'b1 || CYC_O !== 1'b1) begin
        errors++; $display("FAIL write_hold adr=%h dat=%h we=%b cyc=%b want 00000010/deadbeef/1/1", ADR_O, DAT_O, WE_O, CYC_O);
      end
    end
    checks++; if (stb_cyc !== 4) begin errors++; $display("FAIL write_stb_cycles got=%0d want=4", stb_cyc); end
    checks++; if (rsp_valid !== 1'b1 || WE_O !== 1'b0 || CYC_O !== 1'b0) begin errors++; $display("FAIL write_rsp_timing vld=%b we=%b cyc=%b want 1/0/0", rsp_valid, WE_O, CYC_O); end
    @(negedge CLK_I);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL write_pulse_width got=%b want=0", rsp_valid); end
    repeat (3) @(negedge CLK_I);
    checks++; if (rsp_cnt - base !== 1) begin errors++; $display("FAIL write_rsp_count got=%0d want=1", rsp_cnt - base); end
    @(posedge CLK_I); #1;
  endtask

  task automatic test_read;
    logic ok;
    int stb_cyc;
    ack_delay = 0; ack_hold = 0; slave_data = 32'hDEAD_BEEF; stb_cyc = 0;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    send_cmd(1'b0, 32'h0000_0010, 32'h1234_5678, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL read_accept got=%b want=1", ok); end
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK_I);
      checks++; if (WE_O !== 1'b0) begin errors++; $display("FAIL read_we got=%b want=0", WE_O); end
      if (STB_O !== 1'b1) break;
      stb_cyc++;
      checks++; if (DAT_O !== 32'hDEAD_BEEF || ADR_O !== 32'h10) begin errors++; $display("FAIL read_hold adr=%h dat=%h want 00000010/deadbeef", ADR_O, DAT_O); end
    end
    checks++; if (stb_cyc !== 1) begin errors++; $display("FAIL read_min_latency stb_cycles got=%0d want=1", stb_cyc); end
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rsp vld=%b rdata=%h want 1/deadbeef", rsp_valid, rsp_rdata); end
    repeat (4) @(negedge CLK_I);
    checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata_hold got=%h want=deadbeef", rsp_rdata); end
    @(posedge CLK_I); #1;
  endtask

  task automatic test_back_to_back;
    logic ok1, ok2, okw;
    int base, bad_base;
    ack_delay = 1; ack_hold = 2; slave_data = 32'hCAFE_F00D;
    base = rsp_cnt; bad_base = bad_rise;
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'hCAFE_F00D});
    send_cmd(1'b1, 32'h20, 32'h1111_1111, ok1);
    send_cmd(1'b0, 32'h24, 32'h0, ok2);
    checks++; if ({ok1, ok2} !== 2'b11) begin errors++; $display("FAIL b2b_accept got=%b want=11", {ok1, ok2}); end
    wait_rsp(base + 2, okw);
    checks++; if (okw !== 1'b1) begin errors++; $display("FAIL b2b_rsp_timeout got=%0d rsps want=2", rsp_cnt - base); end
    repeat (6) @(negedge CLK_I);
    checks++; if (rsp_cnt - base !== 2) begin errors++; $display("FAIL b2b_rsp_count got=%0d want=2", rsp_cnt - base); end
    checks++; if (bad_rise !== bad_base) begin errors++; $display("FAIL b2b_stb_under_ack got=%0d want=%0d", bad_rise, bad_base); end
    ack_hold = 0;
    @(posedge CLK_I); #1;
  endtask

  task automatic test_ack_in_idle;
    logic ok, okw;
    int base;
    base = rsp_cnt;
    force_ack = 1;
    repeat (2) @(posedge CLK_I);
    @(negedge CLK_I);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL idle_ack_ready got=%b want=0", cmd_ready); end
    cmd_valid = 1; cmd_we = 0; cmd_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_I);
      checks++; if (STB_O !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL idle_ack_hold stb=%b ready=%b want 0/0", STB_O, cmd_ready); end
    end
    checks++; if (rsp_cnt !== base) begin errors++; $display("FAIL idle_ack_spurious got=%0d want=%0d", rsp_cnt, base); end
    @(posedge CLK_I); #1;
    force_ack = 0; cmd_valid = 0;
    ack_delay = 2; slave_data = 32'h600D_F00D;
    exp_q.push_back({1'b0, 32'h600D_F00D});
    send_cmd(1'b0, 32'h40, 32'h0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL idle_ack_recover got=%b want=1", ok); end
    wait_rsp(base + 1, okw);
    checks++; if (okw !== 1'b1) begin errors++; $display("FAIL idle_ack_rsp got=%0d rsps want=1", rsp_cnt - base); end
  endtask

  task automatic test_reset_mid_bus;
    logic ok, okw;
    int base;
    ack_delay = 1000; base = rsp_cnt;
    send_cmd(1'b1, 32'h30, 32'h5555_AAAA, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstbus_accept got=%b want=1", ok); end
    repeat (2) @(negedge CLK_I);
    checks++; if (STB_O !== 1'b1) begin errors++; $display("FAIL rstbus_stb_before got=%b want=1", STB_O); end
    RST_I = 0;
    #1;
    checks++; if (STB_O !== 1'b0 || CYC_O !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rstbus_abort stb=%b cyc=%b vld=%b want 0/0/0", STB_O, CYC_O, rsp_valid); end
    repeat (2) @(negedge CLK_I);
    RST_I = 1;
    repeat (5) @(negedge CLK_I);
    checks++; if (rsp_cnt !== base) begin errors++; $display("FAIL rstbus_no_rsp got=%0d want=%0d", rsp_cnt, base); end
    @(posedge CLK_I); #1;
    ack_delay = 1; slave_data = 32'h0BAD_CAFE;
    exp_q.push_back({1'b0, 32'h0BAD_CAFE});
    send_cmd(1'b0, 32'h34, 32'h0, ok);
    wait_rsp(base + 1, okw);
    checks++; if ({ok, okw} !== 2'b11) begin errors++; $display("FAIL rstbus_next_cmd got=%b want=11", {ok, okw}); end
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout;
    logic ok;
    int stb_cyc;
    // Slave never answers: abort with error after 16 BUS cycles.
    ack_delay = 1000; stb_cyc = 0;
    exp_q.push_back({1'b1, 32'h0});
    send_cmd(1'b0, 32'h50, 32'h0, ok);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK_I);
      if (CYC_O !== 1'b1) break;
      stb_cyc++;
    end
    checks++; if (stb_cyc !== 16) begin errors++; $display("FAIL tmo_cycles got=%0d want=16", stb_cyc); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rsp vld=%b err=%b rdata=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    @(posedge CLK_I); #1;
    // ACK sampled at the same edge the timeout would fire: ACK wins.
    ack_delay = 15; slave_data = 32'h7777_1616; stb_cyc = 0;
    exp_q.push_back({1'b0, 32'h7777_1616});
    send_cmd(1'b0, 32'h54, 32'h0, ok);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK_I);
      if (CYC_O !== 1'b1) break;
      stb_cyc++;
    end
    checks++; if (stb_cyc !== 16) begin errors++; $display("FAIL tmo_ack16_cycles got=%0d want=16", stb_cyc); end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL tmo_ack16_rsp vld=%b err=%b want 1/0", rsp_valid, rsp_err); end
    repeat (3) @(negedge CLK_I);
    @(posedge CLK_I); #1;
  endtask
`endif

  initial begin
    RST_I = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    #2;
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_ack_in_idle;
    test_reset_mid_bus;
`ifdef WB_TIMEOUT_EN
    test_timeout;
`endif
    repeat (4) @(negedge CLK_I);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected got=%0d want=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_master_interface.md
WB_MASTER_INTERFACE -- requirements
Module: wb_master_interface

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max cycles waiting for ACK_I before abort (used only with WB_TIMEOUT_EN).
REQ-002 CLK_I  input  1  single clock; all logic on rising edge.
REQ-003 RST_I  input  1  reset, asynchronous assert, active-low.
REQ-004 cmd_valid  input  1  user requests a bus transaction.
REQ-005 cmd_ready  output  1  block accepts the command this cycle.
REQ-006 cmd_we  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  transaction address.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  one-cycle pulse, transaction complete.
REQ-010 rsp_rdata  output  32  read data, valid with rsp_valid.
REQ-011 rsp_err  output  1  transaction aborted by timeout, valid with rsp_valid.
REQ-012 ADR_O  output  32  Wishbone address.
REQ-013 DAT_O  output  32  Wishbone write data.
REQ-014 WE_O  output  1  Wishbone write enable.
REQ-015 STB_O  output  1  Wishbone strobe.
REQ-016 CYC_O  output  1  Wishbone cycle.
REQ-017 DAT_I  input  32  Wishbone read data from slave.
REQ-018 ACK_I  input  1  Wishbone acknowledge from slave; slave holds it high until STB_O and CYC_O both low.

Function
REQ-019 States: IDLE, BUS, RELEASE; encoded, registered, reset to IDLE.
REQ-020 cmd_ready = 1 only in IDLE with ACK_I low; combinational from state and ACK_I.
REQ-021 IDLE, cmd_valid & cmd_ready: latch cmd_addr->ADR_O, cmd_we->WE_O, cmd_wdata->DAT_O (write only, else DAT_O holds); STB_O = CYC_O = 1 next cycle; go to BUS.
REQ-022 BUS: ADR_O, DAT_O, WE_O, STB_O, CYC_O held stable until ACK_I sampled high.
REQ-023 BUS, ACK_I = 1: capture DAT_I into rsp_rdata if read (write: rsp_rdata = 0); STB_O = CYC_O = WE_O = 0; rsp_valid = 1 with rsp_err = 0 for exactly one cycle; go to RELEASE.
REQ-024 RELEASE: wait for ACK_I = 0, then IDLE; no new command accepted before ACK_I low (prevents stale-ACK double completion).
REQ-025 Latency: ACK_I arriving N cycles after STB_O rises gives rsp_valid the cycle after ACK_I is sampled; minimum command-to-response 3 cycles.
REQ-026 cmd_valid while not in IDLE ignored (cmd_ready = 0); the command must be held by the user.
REQ-027 rsp_rdata holds its value until the next completion.
REQ-028 ACK_I high in IDLE (slave misbehaviour): block stays in IDLE with cmd_ready = 0 until ACK_I low.

Reset
REQ-029 RST_I low: state = IDLE, STB_O = CYC_O = WE_O = 0, ADR_O = DAT_O = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, timeout counter = 0, immediately, with no clock required.
REQ-030 Reset mid-transaction aborts without response; no rsp_valid issued for the aborted command.

Configuration
REQ-031 Macro WB_TIMEOUT_EN defined: counter increments each BUS cycle; on reaching TIMEOUT_CYCLES without ACK_I, drop STB_O/CYC_O, pulse rsp_valid with rsp_err = 1 and rsp_rdata = 0, go to RELEASE; ACK_I and timeout in the same cycle -> ACK wins (rsp_err = 0).
REQ-032 Macro undefined: no counter logic, rsp_err tied 0, BUS waits indefinitely for ACK_I.

Verification
REQ-033 Write: cmd addr 0x0000_0010, wdata 0xDEAD_BEEF, we=1; slave ACKs after 3 cycles -> ADR_O/DAT_O stable for those cycles, WE_O = 1, single rsp_valid, rsp_err = 0.
REQ-034 Read: addr 0x0000_0010, slave returns 0xDEAD_BEEF with ACK -> rsp_rdata = 0xDEAD_BEEF on the rsp_valid cycle, WE_O = 0 throughout.
REQ-035 Back-to-back: cmd_valid held high for 2 commands, slave holds ACK 2 cycles after STB_O drop -> second STB_O rises only after ACK_I low; exactly 2 rsp_valid pulses.
REQ-036 Reset mid-BUS: RST_I low while STB_O = 1 -> STB_O/CYC_O low same cycle, no rsp_valid; next command completes normally.
REQ-037 WB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, slave never ACKs -> CYC_O drops after 16 BUS cycles, rsp_valid with rsp_err = 1, rsp_rdata = 0; ACK on cycle 16 -> rsp_err = 0.
